time_adjust_arb: RTL and testbench

TIME_ADJUST_ARB -- requirements
Module: time_adjust_arb

---
 rtl/time_adjust_arb.sv | 113 +++++++++++
 tb/tb_time_adjust_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_adjust_arb.sv
// time_adjust_arb: merges the 1 s tick and four auto-repeating time-set buttons
// into one prioritised valid/ready command stream toward the time counter.
module time_adjust_arb #(
   parameter int HOLD_CYCLES   = 12000000,
   parameter int REPEAT_CYCLES = 3000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1s,
   input  logic [3:0] btn_lvl,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [2:0] cmd_op,
   output logic       tick_overrun
);
   typedef enum logic [1:0] {RELEASED, WAIT, REPEAT} rpt_t;
   typedef enum logic {IDLE, ISSUE} arb_t;
   localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
   localparam logic [23:0] RPT_LAST  = 24'(REPEAT_CYCLES - 1);

   logic [3:0] prev_q, prev_d;
   logic [3:0] btn_evt;
   logic [4:0] pend_q, pend_d, req, grant_vec;
   logic       ovr_q, ovr_d, grant;
   logic       cmd_valid_q, valid_d;
   logic [2:0] cmd_op_q, op_d, top_op;
   arb_t       state_q, state_d;

   for (genvar g = 0; g < 4; g++) begin : g_btn
      rpt_t        rpt_q, rpt_d;
      logic [23:0] cnt_q, cnt_d;
      logic        evt;
      always_comb begin
         rpt_d = rpt_q;
         cnt_d = cnt_q;
         evt   = 1'b0;
         if (!btn_lvl[g]) begin
            rpt_d = RELEASED;
            cnt_d = '0;
         end else if (rpt_q == RELEASED) begin
            if (!prev_q[g]) begin
               evt   = 1'b1;
               rpt_d = WAIT;
               cnt_d = '0;
            end
         end else if (cnt_q == (rpt_q == WAIT ? HOLD_LAST : RPT_LAST)) begin
            evt   = 1'b1;
            rpt_d = REPEAT;
            cnt_d = '0;
         end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
         end
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rpt_q <= RELEASED;
            cnt_q <= '0;
         end else begin
            rpt_q <= rpt_d;
            cnt_q <= cnt_d;
         end
      end
      assign btn_evt[g] = evt;
   end

   // A new request in the grant cycle keeps its flag set, so set beats clear.
   always_comb begin
      prev_d    = btn_lvl;
      req       = {btn_evt, tick_1s};
      grant     = (state_q == ISSUE) && cmd_ready;
      grant_vec = grant ? (5'b1 << (cmd_op_q - 3'd1)) : 5'b0;
      pend_d    = (pend_q & ~grant_vec) | req;
      ovr_d     = ovr_q | (tick_1s & pend_q[0] & ~grant_vec[0]);
      top_op    = 3'd0;
      for (int i = 4; i >= 0; i--)
         if (pend_q[i]) top_op = 3'(i + 1);
      state_d = state_q;
      valid_d = cmd_valid_q;
      op_d    = cmd_op_q;
      if (state_q == IDLE && |pend_q) begin
         state_d = ISSUE;
         valid_d = 1'b1;
         op_d    = top_op;
      end else if (grant) begin
         state_d = IDLE;
         valid_d = 1'b0;
         op_d    = 3'd0;
      end
   end

   // History resets high so a button held through reset is not seen as a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q      <= '1;
         pend_q      <= '0;
         ovr_q       <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= 3'd0;
         state_q     <= IDLE;
      end else begin
         prev_q      <= prev_d;
         pend_q      <= pend_d;
         ovr_q       <= ovr_d;
         cmd_valid_q <= valid_d;
         cmd_op_q    <= op_d;
         state_q     <= state_d;
      end
   end

   assign cmd_valid    = cmd_valid_q;
   assign cmd_op       = cmd_op_q;
   assign tick_overrun = ovr_q;
endmodule

// File: tb/tb_time_adjust_arb.sv
// tb_time_adjust_arb: directed scenarios plus randomized traffic, compared every
// cycle against a timestamp-based model of the tick/button arbitration rules.
module tb_time_adjust_arb;
   localparam int HOLD = 8;
   localparam int REP  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1s = 1'b0;
   logic [3:0] btn_lvl = 4'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [2:0] cmd_op;
   logic       tick_overrun;

   int checks = 0;
   int errors = 0;

   time_adjust_arb #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tick_1s(tick_1s),
      .btn_lvl(btn_lvl),
      .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid),
      .cmd_op(cmd_op),
      .tick_overrun(tick_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Model: requests are a set of pending ops; a button request fires on the press
   // cycle and then at press+HOLD+k*REP while still held.
   int       m_cyc = 0;
   int       m_start[4] = '{-1, -1, -1, -1};
   bit [3:0] m_prev = 4'hF;
   bit [4:0] m_pend = 5'b0;
   bit       m_valid = 1'b0;
   bit       m_ovr = 1'b0;
   bit [2:0] m_op = 3'd0;

   always @(posedge clk) begin
      int       st[4];
      bit [4:0] ev, pend;
      bit       v, ovr, grant, found;
      bit [2:0] op;
      int       d;
      st = m_start;
      pend = m_pend;
      v = m_valid;
      op = m_op;
      ovr = m_ovr;
      if (!rst_n) begin
         st = '{-1, -1, -1, -1};
         pend = 5'b0;
         v = 1'b0;
         op = 3'd0;
         ovr = 1'b0;
         m_prev <= 4'hF;
      end else begin
         ev = 5'b0;
         ev[0] = tick_1s;
         for (int i = 0; i < 4; i++) begin
            if (!btn_lvl[i]) st[i] = -1;
            else if (!m_prev[i]) begin
               st[i] = m_cyc;
               ev[i+1] = 1'b1;
            end else if (st[i] >= 0) begin
               d = m_cyc - st[i];
               if (d >= HOLD && (d - HOLD) % REP == 0) ev[i+1] = 1'b1;
            end
         end
         m_prev <= btn_lvl;
         grant = m_valid && cmd_ready;
         if (tick_1s && m_pend[0] && !(grant && m_op == 3'd1)) ovr = 1'b1;
         if (grant) pend[m_op-1] = 1'b0;
         pend |= ev;
         if (m_valid) begin
            if (cmd_ready) begin
               v = 1'b0;
               op = 3'd0;
            end
         end else if (m_pend != 0) begin
            found = 1'b0;
            for (int i = 0; i < 5; i++)
               if (m_pend[i] && !found) begin
                  found = 1'b1;
                  op = 3'(i + 1);
               end
            v = 1'b1;
         end
      end
      m_start <= st;
      m_pend  <= pend;
      m_valid <= v;
      m_op    <= op;
      m_ovr   <= ovr;
      m_cyc   <= m_cyc + 1;
   end

   always @(negedge clk) begin
      chk("model_valid", int'(cmd_valid), rst_n ? int'(m_valid) : 0);
      chk("model_op", int'(cmd_op), rst_n ? int'(m_op) : 0);
      chk("model_ovr", int'(tick_overrun), rst_n ? int'(m_ovr) : 0);
   end

   initial begin
      int cnt, seen, gi;
      int exp_at[4] = '{2, 10, 14, 18};
      cyc(3);
      chk("reset_valid", int'(cmd_valid), 0);
      chk("reset_op", int'(cmd_op), 0);
      chk("reset_ovr", int'(tick_overrun), 0);
      rst_n = 1'b1;
      cmd_ready = 1'b1;
      cyc(2);
      // single tick
      tick_1s = 1'b1;
      cyc(1);
      tick_1s = 1'b0;
      chk("tick_c1_valid", int'(cmd_valid), 0);
      cyc(1);
      chk("tick_c2_valid", int'(cmd_valid), 1);
      chk("tick_c2_op", int'(cmd_op), 1);
      cyc(1);
      chk("tick_c3_valid", int'(cmd_valid), 0);
      chk("tick_c3_op", int'(cmd_op), 0);
      cyc(1);
      chk("tick_c4_valid", int'(cmd_valid), 0);
      cyc(3);
      // tick and MIN_INC together
      tick_1s = 1'b1;
      btn_lvl[2] = 1'b1;
      cyc(1);
      tick_1s = 1'b0;
      cyc(1);
      chk("both_c2_op", int'(cmd_op), 1);
      cyc(1);
      chk("both_c3_valid", int'(cmd_valid), 0);
      cyc(1);
      chk("both_c4_valid", int'(cmd_valid), 1);
      chk("both_c4_op", int'(cmd_op), 4);
      cyc(1);
      btn_lvl[2] = 1'b0;
      chk("both_c5_valid", int'(cmd_valid), 0);
      cyc(4);
      // HOUR_DEC stalled while a tick arrives
      cmd_ready = 1'b0;
      btn_lvl[1] = 1'b1;
      cyc(2);
      chk("stall_c2_op", int'(cmd_op), 3);
      tick_1s = 1'b1;
      cyc(1);
      tick_1s = 1'b0;
      for (int c = 3; c < 12; c++) begin
         if (c == 4) btn_lvl[1] = 1'b0;
         chk("stall_hold_op", int'(cmd_op), 3);
         chk("stall_hold_valid", int'(cmd_valid), 1);
         cyc(1);
      end
      cmd_ready = 1'b1;
      chk("stall_grant_op", int'(cmd_op), 3);
      cyc(1);
      chk("stall_gap_valid", int'(cmd_valid), 0);
      cyc(1);
      chk("stall_next_op", int'(cmd_op), 1);
      cyc(1);
      chk("stall_end_valid", int'(cmd_valid), 0);
      cyc(3);
      // two ticks while stalled
      cmd_ready = 1'b0;
      chk("ovr_pre", int'(tick_overrun), 0);
      tick_1s = 1'b1;
      cyc(1);
      tick_1s = 1'b0;
      cyc(2);
      tick_1s = 1'b1;
      cyc(1);
      tick_1s = 1'b0;
      chk("ovr_set", int'(tick_overrun), 1);
      cyc(2);
      cmd_ready = 1'b1;
      chk("ovr_grant_op", int'(cmd_op), 1);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         cyc(1);
         if (cmd_valid) seen++;
      end
      chk("ovr_one_tick", seen, 0);
      chk("ovr_sticky", int'(tick_overrun), 1);
      rst_n = 1'b0;
      #1 chk("ovr_cleared", int'(tick_overrun), 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      // reset while a command is outstanding
      cmd_ready = 1'b0;
      tick_1s = 1'b1;
      cyc(1);
      tick_1s = 1'b0;
      cyc(1);
      chk("rst_issue_valid", int'(cmd_valid), 1);
      rst_n = 1'b0;
      #1 chk("rst_drop_valid", int'(cmd_valid), 0);
      chk("rst_drop_op", int'(cmd_op), 0);
      cyc(1);
      rst_n = 1'b1;
      cmd_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         cyc(1);
         if (cmd_valid) seen++;
      end
      chk("rst_no_regrant", seen, 0);
      // auto-repeat of HOUR_INC
      cnt = 0;
      gi = 0;
      for (int c = 0; c < 30; c++) begin
         btn_lvl[0] = (c < 20);
         if (cmd_valid && cmd_op == 3'd2) begin
            if (gi < 4) chk("rpt_time", c, exp_at[gi]);
            gi++;
            cnt++;
         end
         cyc(1);
      end
      chk("rpt_grants", cnt, 4);
      // button held through reset
      rst_n = 1'b0;
      btn_lvl[3] = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 14; c++) begin
         cyc(1);
         if (cmd_valid) seen++;
      end
      chk("held_no_cmd", seen, 0);
      btn_lvl[3] = 1'b0;
      cyc(1);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         btn_lvl[3] = (c < 3);
         if (cmd_valid && cmd_op == 3'd5) cnt++;
         cyc(1);
      end
      chk("held_repress", cnt, 1);
      // randomized traffic, checked by the model every cycle
      for (int c = 0; c < 4000; c++) begin
         tick_1s = ($urandom_range(7) == 0);
         for (int i = 0; i < 4; i++)
            if ($urandom_range(11) == 0) btn_lvl[i] = ~btn_lvl[i];
         cmd_ready = ($urandom_range(9) < 7);
         rst_n = ($urandom_range(499) != 0);
         cyc(1);
      end
      rst_n = 1'b1;
      tick_1s = 1'b0;
      btn_lvl = 4'b0;
      cyc(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
